// File: rtl/rv32_branch_predictor_pkg.sv
// Shared branch definitions: resolved-branch op codes and 2-bit counter states
// used by the fetch-stage branch predictor and its counter sub-module.
package rv32_branch_predictor_pkg;

  // Branch op codes as produced by decode and returned by execute.
  typedef enum logic [1:0] {
    RV32_BRANCH_OP_NEVER    = 2'd0,
    RV32_BRANCH_OP_ZERO     = 2'd1,
    RV32_BRANCH_OP_NON_ZERO = 2'd2,
    RV32_BRANCH_OP_ALWAYS   = 2'd3
  } rv32_branch_op_e;

  localparam int unsigned RV32_BRANCH_CTR_W = 2;

  // Saturating counter encoding; MSB set means predict taken.
  localparam logic [RV32_BRANCH_CTR_W-1:0] RV32_BRANCH_CTR_STRONG_NT = 2'b00;
  localparam logic [RV32_BRANCH_CTR_W-1:0] RV32_BRANCH_CTR_WEAK_NT   = 2'b01;
  localparam logic [RV32_BRANCH_CTR_W-1:0] RV32_BRANCH_CTR_WEAK_T    = 2'b10;
  localparam logic [RV32_BRANCH_CTR_W-1:0] RV32_BRANCH_CTR_STRONG_T  = 2'b11;
  localparam logic [RV32_BRANCH_CTR_W-1:0] RV32_BRANCH_CTR_RESET     = RV32_BRANCH_CTR_WEAK_NT;

endpackage

// File: rtl/rv32_branch_sat_counter.sv
// 2-bit saturating counter step.
// Ports: ctr_in  - current counter state
//        taken_in - resolved outcome (1 = step up, 0 = step down)
//        ctr_out - next counter state, clamped at strong-NT / strong-T
module rv32_branch_sat_counter
  import rv32_branch_predictor_pkg::*;
(
  input  logic [RV32_BRANCH_CTR_W-1:0] ctr_in,
  input  logic                         taken_in,
  output logic [RV32_BRANCH_CTR_W-1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken_in) begin
      if (ctr_in != RV32_BRANCH_CTR_STRONG_T) ctr_out = ctr_in + 2'(1);
    end else begin
      if (ctr_in != RV32_BRANCH_CTR_STRONG_NT) ctr_out = ctr_in - 2'(1);
    end
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped 2-bit counter table plus
// a tagged BTB, predicted combinationally and trained one edge after resolve.
// Ports: clk, reset (async, active-high)
//        fetch_pc_in -> predicted_taken_out, predicted_pc_out (same cycle)
//        update_valid_in/op/pc/taken/target - resolved branch from execute
//        invalidate_in - clears every BTB valid bit (counters kept)
module rv32_branch_predictor
  import rv32_branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc_in,
  output logic        predicted_taken_out,
  output logic [31:0] predicted_pc_out,
  input  logic        update_valid_in,
  input  logic [1:0]  update_op_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [31:0] update_target_in,
  input  logic        invalidate_in
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [RV32_BRANCH_CTR_W-1:0] ctr_q [ENTRIES];
  logic [RV32_BRANCH_CTR_W-1:0] ctr_d [ENTRIES];
  logic [ENTRIES-1:0]           valid_q, valid_d;
  logic [TAG_BITS-1:0]          tag_q [ENTRIES];
  logic [30:0]                  target_q [ENTRIES];

  logic [INDEX_BITS-1:0]        fetch_idx, upd_idx;
  logic [TAG_BITS-1:0]          fetch_tag, upd_tag;
  logic                         fetch_hit, upd_hit, btb_we;
  logic [RV32_BRANCH_CTR_W-1:0] ctr_step;
  rv32_branch_op_e              upd_op;

  // Low PC bits and target bit 0 carry no table information.
  logic unused_bits;
  assign unused_bits = ^{update_pc_in, update_target_in[0]};

  // Prediction path reads pre-edge table contents; no write bypass.
  assign fetch_idx           = fetch_pc_in[INDEX_BITS+1:2];
  assign fetch_tag           = fetch_pc_in[INDEX_BITS+2 +: TAG_BITS];
  assign fetch_hit           = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign predicted_taken_out = fetch_hit && ctr_q[fetch_idx][1];
  assign predicted_pc_out    = predicted_taken_out ? {target_q[fetch_idx], 1'b0}
                                                   : fetch_pc_in + 32'd4;

  assign upd_idx = update_pc_in[INDEX_BITS+1:2];
  assign upd_tag = update_pc_in[INDEX_BITS+2 +: TAG_BITS];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_op  = rv32_branch_op_e'(update_op_in);

  rv32_branch_sat_counter u_sat_counter (
    .ctr_in   (ctr_q[upd_idx]),
    .taken_in (update_taken_in),
    .ctr_out  (ctr_step)
  );

  // Training: counter step, BTB allocate/replace on taken, invalidate wins on valid.
  always_comb begin
    ctr_d   = ctr_q;
    valid_d = valid_q;
    btb_we  = 1'b0;
    if (update_valid_in) begin
      case (upd_op)
        RV32_BRANCH_OP_ZERO, RV32_BRANCH_OP_NON_ZERO: begin
          if (update_taken_in) begin
            btb_we         = 1'b1;
            // A newly allocated entry starts weakly taken, not stepped from the alias.
            ctr_d[upd_idx] = upd_hit ? ctr_step : RV32_BRANCH_CTR_WEAK_T;
          end else begin
            ctr_d[upd_idx] = ctr_step;
          end
        end
        RV32_BRANCH_OP_ALWAYS: begin
          btb_we         = 1'b1;
          ctr_d[upd_idx] = RV32_BRANCH_CTR_STRONG_T;
        end
        default: ;
      endcase
    end
    if (btb_we)        valid_d[upd_idx] = 1'b1;
    if (invalidate_in) valid_d = '0;
  end

  // Counter and valid arrays carry the only resettable state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= RV32_BRANCH_CTR_RESET;
      valid_q <= '0;
    end else begin
      ctr_q   <= ctr_d;
      valid_q <= valid_d;
    end
  end

  // Tag and target storage: written on BTB allocate, never reset.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= update_target_in[31:1];
    end
  end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed bench for rv32_branch_predictor: each expected prediction is queued
// when the fetch PC is driven and popped when the combinational output is sampled.
module tb_rv32_branch_predictor;
  import rv32_branch_predictor_pkg::*;

  localparam int unsigned INDEX_BITS = 6;
  localparam int unsigned TAG_BITS   = 8;
  localparam logic [31:0] ALIAS_PC   = 32'h200 + (32'd4 << INDEX_BITS);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc_in;
  logic        predicted_taken_out;
  logic [31:0] predicted_pc_out;
  logic        update_valid_in;
  logic [1:0]  update_op_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic [31:0] update_target_in;
  logic        invalidate_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    string       name;
  } exp_t;

  exp_t sb[$];

  rv32_branch_predictor #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_pc_in         (fetch_pc_in),
    .predicted_taken_out (predicted_taken_out),
    .predicted_pc_out    (predicted_pc_out),
    .update_valid_in     (update_valid_in),
    .update_op_in        (update_op_in),
    .update_pc_in        (update_pc_in),
    .update_taken_in     (update_taken_in),
    .update_target_in    (update_target_in),
    .invalidate_in       (invalidate_in)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string name, input logic t, input logic [31:0] pc);
    exp_t e;
    e.taken = t;
    e.pc    = pc;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic check_pred();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed no entry, expected one");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (predicted_taken_out === e.taken) else begin
      errors++;
      $error("FAIL %s taken: observed %0b expected %0b", e.name, predicted_taken_out, e.taken);
    end
    checks++;
    assert (predicted_pc_out === e.pc) else begin
      errors++;
      $error("FAIL %s pc: observed %08h expected %08h", e.name, predicted_pc_out, e.pc);
    end
  endtask

  // Drive a fetch PC, queue its expectation, sample after settling.
  task automatic predict(input string name, input logic [31:0] pc, input logic t,
                         input logic [31:0] epc);
    fetch_pc_in = pc;
    push_exp(name, t, epc);
    #1;
    check_pred();
  endtask

  // One-cycle training pulse; returns 1 time unit after the capturing edge.
  task automatic train(input logic [1:0] op, input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic inv);
    update_valid_in  = 1'b1;
    update_op_in     = op;
    update_pc_in     = pc;
    update_taken_in  = taken;
    update_target_in = target;
    invalidate_in    = inv;
    @(posedge clk);
    #1;
    update_valid_in = 1'b0;
    invalidate_in   = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    fetch_pc_in      = 32'h0;
    update_valid_in  = 1'b0;
    update_op_in     = RV32_BRANCH_OP_NEVER;
    update_pc_in     = 32'h0;
    update_taken_in  = 1'b0;
    update_target_in = 32'h0;
    invalidate_in    = 1'b0;

    #2;
    predict("in_reset", 32'h100, 1'b0, 32'h104);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Cold table
    predict("cold_100", 32'h100, 1'b0, 32'h104);
    predict("wrap_pc", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // First taken conditional allocates, ctr 01 -> 10
    train(RV32_BRANCH_OP_ZERO, 32'h100, 1'b1, 32'h80, 1'b0);
    predict("first_taken", 32'h100, 1'b1, 32'h80);
    predict("other_idx", 32'h104, 1'b0, 32'h108);

    // Saturate at 11, one NT -> 10 still taken, second NT -> 01
    repeat (3) train(RV32_BRANCH_OP_NON_ZERO, 32'h100, 1'b1, 32'h80, 1'b0);
    train(RV32_BRANCH_OP_NON_ZERO, 32'h100, 1'b0, 32'h80, 1'b0);
    predict("sat_then_nt1", 32'h100, 1'b1, 32'h80);
    train(RV32_BRANCH_OP_NON_ZERO, 32'h100, 1'b0, 32'h80, 1'b0);
    predict("nt2_weak_nt", 32'h100, 1'b0, 32'h104);

    // NEVER op leaves state alone
    train(RV32_BRANCH_OP_NEVER, 32'h100, 1'b1, 32'h900, 1'b0);
    predict("op_never", 32'h100, 1'b0, 32'h104);

    // Jump ignores taken flag, forces 11, target bit 0 cleared
    train(RV32_BRANCH_OP_ALWAYS, 32'h200, 1'b0, 32'h3001, 1'b0);
    predict("jump_hit", 32'h200, 1'b1, 32'h3000);
    predict("jump_alias", ALIAS_PC, 1'b0, ALIAS_PC + 32'd4);
    predict("replaced_old", 32'h100, 1'b0, 32'h104);

    // Tag-mismatch taken conditional replaces with ctr 10, so one NT drops it
    train(RV32_BRANCH_OP_ZERO, ALIAS_PC, 1'b1, 32'h400, 1'b0);
    predict("alias_replace", ALIAS_PC, 1'b1, 32'h400);
    predict("evicted_jump", 32'h200, 1'b0, 32'h204);
    train(RV32_BRANCH_OP_ZERO, ALIAS_PC, 1'b0, 32'h400, 1'b0);
    predict("replace_ctr10", ALIAS_PC, 1'b0, ALIAS_PC + 32'd4);

    // Same-cycle fetch and update: old prediction now, new one after the edge
    fetch_pc_in      = ALIAS_PC;
    update_valid_in  = 1'b1;
    update_op_in     = RV32_BRANCH_OP_ZERO;
    update_pc_in     = ALIAS_PC;
    update_taken_in  = 1'b1;
    update_target_in = 32'h480;
    push_exp("same_cycle_old", 1'b0, ALIAS_PC + 32'd4);
    #1;
    check_pred();
    @(posedge clk);
    #1;
    update_valid_in = 1'b0;
    push_exp("same_cycle_new", 1'b1, 32'h480);
    #1;
    check_pred();

    // Invalidate beats a simultaneous allocating jump
    train(RV32_BRANCH_OP_ALWAYS, 32'h200, 1'b1, 32'h3000, 1'b1);
    predict("inv_jump", 32'h200, 1'b0, 32'h204);
    predict("inv_alias", ALIAS_PC, 1'b0, ALIAS_PC + 32'd4);

    // Async reset mid-cycle during an update
    train(RV32_BRANCH_OP_ZERO, 32'h104, 1'b1, 32'h900, 1'b0);
    predict("pre_reset_hit", 32'h104, 1'b1, 32'h900);
    update_valid_in  = 1'b1;
    update_op_in     = RV32_BRANCH_OP_ALWAYS;
    update_pc_in     = 32'h104;
    update_taken_in  = 1'b1;
    update_target_in = 32'hA00;
    #2;
    reset = 1'b1;
    predict("async_reset", 32'h104, 1'b0, 32'h108);
    @(posedge clk);
    #1;
    predict("reset_held", 32'h104, 1'b0, 32'h108);
    @(negedge clk);
    reset           = 1'b0;
    update_valid_in = 1'b0;
    #1;
    predict("post_reset_104", 32'h104, 1'b0, 32'h108);
    predict("post_reset_alias", ALIAS_PC, 1'b0, ALIAS_PC + 32'd4);
    train(RV32_BRANCH_OP_ZERO, 32'h104, 1'b1, 32'h900, 1'b0);
    predict("post_reset_train", 32'h104, 1'b1, 32'h900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
